// File: rtl/adc_sample_spi_framer.sv
`timescale 1ns/1ps
// adc_sample_spi_framer
// Buffers ADC samples in a small FIFO, tags each with a sequence number and a
// drop flag, and streams them out as SPI mode-0 frames, MSB first.
//
// state | meaning
// IDLE  | csn high; pops the FIFO head into the shift register when non-empty
// SHIFT | csn low; spi_clk toggles every CLK_DIV cycles, mosi moves on falling edges
// GAP   | csn high for CS_GAP cycles before the next frame may start
module adc_sample_spi_framer #(
  parameter int ADC_WIDTH = 8,
  parameter int SEQ_BITS  = 7,
  parameter int FIFO_AW   = 3,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_rdy,
  output logic                 spi_csn,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 busy
);

  localparam int FRAME_W = 1 + SEQ_BITS + ADC_WIDTH;
  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [SEQ_BITS-1:0] SEQ_ONE = SEQ_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [FRAME_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [SEQ_BITS-1:0] seq;
  logic                drop_pend;
  logic                fifo_full;
  logic                wr_accept;
  logic                pop;
  logic [FRAME_W-1:0]  head;
  logic [FRAME_W-1:0]  wr_word;

  // Serializer state
  state_t             state, state_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               csn_n;
  logic               sclk_n;
  logic               busy_n;

  assign fifo_full = (fifo_level == LVL_FULL);
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign wr_accept = sample_rdy && (!fifo_full || pop);
  assign wr_word   = {drop_pend, seq, sample_in};
  assign head      = mem[rd_ptr];
  assign spi_mosi  = shreg[FRAME_W-1];

  // Sample storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // FIFO pointers, occupancy, sequence counter and pending-drop marker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      seq        <= '0;
      drop_pend  <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_accept, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (sample_rdy) begin
        seq <= seq + SEQ_ONE;
      end
      if (wr_accept) begin
        drop_pend <= 1'b0;
      end else if (sample_rdy) begin
        drop_pend <= 1'b1;
      end
    end
  end

  // Serializer state register and registered SPI outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      spi_csn <= 1'b1;
      spi_clk <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      spi_csn <= csn_n;
      spi_clk <= sclk_n;
      busy    <= busy_n;
    end
  end

  // Next-state logic: load on pop, shift on spi_clk falls, count out the gap.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    csn_n   = spi_csn;
    sclk_n  = spi_clk;
    busy_n  = busy;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop     = 1'b1;
          shreg_n = head;
          div_n   = DIV_LAST;
          bit_n   = BIT_LAST;
          csn_n   = 1'b0;
          sclk_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == '0) begin
          div_n = DIV_LAST;
          if (!spi_clk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == '0) begin
              // Last falling boundary closes the frame: clock low and csn high together.
              csn_n   = 1'b1;
              shreg_n = '0;
              gap_n   = GAP_LAST;
              state_n = GAP;
            end else begin
              bit_n   = bit_cnt - BIT_ONE;
              shreg_n = {shreg[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_n = div_cnt - DIV_ONE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt - GAP_ONE;
        end
      end
      default: begin
        csn_n   = 1'b1;
        sclk_n  = 1'b0;
        busy_n  = 1'b0;
        shreg_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_sample_spi_framer.sv
`timescale 1ns/1ps
// Testbench for adc_sample_spi_framer: directed samples, expected frames queued
// at issue time, SPI receiver monitor pops and compares each received frame.
module tb_adc_sample_spi_framer;

  localparam int ADC_WIDTH = 8;
  localparam int SEQ_BITS  = 7;
  localparam int FIFO_AW   = 2;
  localparam int CLK_DIV   = 2;
  localparam int CS_GAP    = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [ADC_WIDTH-1:0] sample_in = '0;
  logic                 sample_rdy = 1'b0;
  logic                 spi_csn;
  logic                 spi_clk;
  logic                 spi_mosi;
  logic [FIFO_AW:0]     fifo_level;
  logic                 busy;

  adc_sample_spi_framer #(
    .ADC_WIDTH(ADC_WIDTH),
    .SEQ_BITS (SEQ_BITS),
    .FIFO_AW  (FIFO_AW),
    .CLK_DIV  (CLK_DIV),
    .CS_GAP   (CS_GAP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sample_in (sample_in),
    .sample_rdy(sample_rdy),
    .spi_csn   (spi_csn),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .fifo_level(fifo_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rx_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // SPI receiver model: sample mosi on spi_clk rise while csn is low.
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          last_high = 0;
  int          bits = 0;
  logic [15:0] rx = '0;
  logic [15:0] exp_word;
  logic        prev_csn = 1'b1;
  logic        prev_clk = 1'b0;
  logic        in_frame = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      in_frame = 1'b0;
      bits     = 0;
      low_cnt  = 0;
      high_cnt = 0;
      prev_csn = 1'b1;
      prev_clk = 1'b0;
    end else begin
      if (!spi_csn) begin
        if (prev_csn) begin
          in_frame  = 1'b1;
          bits      = 0;
          rx        = '0;
          low_cnt   = 0;
          last_high = high_cnt;
        end
        low_cnt++;
        if (spi_clk && !prev_clk) begin
          rx = {rx[14:0], spi_mosi};
          bits++;
        end
      end else begin
        if (!prev_csn && in_frame) begin
          check("csn_low_cycles", low_cnt, 64);
          check("bits_per_frame", bits, 16);
          check("sclk_low_at_frame_end", {31'd0, spi_clk}, 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h, want no frame", rx);
          end else begin
            exp_word = exp_q.pop_front();
            check("frame_word", rx, exp_word);
          end
          rx_log.push_back(rx);
          in_frame = 1'b0;
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_csn = spi_csn;
      prev_clk = spi_clk;
    end
  end

  task automatic send(input logic [7:0] s);
    sample_in  = s;
    sample_rdy = 1'b1;
    @(negedge clk);
    sample_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max, input string name);
    int i;
    for (i = 0; i < max; i++) begin
      if (!busy && fifo_level == 0 && spi_csn) break;
      @(negedge clk);
    end
    check(name, {31'd0, (i < max)}, 1);
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int i;
    for (i = 0; i < max; i++) begin
      if (busy == val) break;
      @(negedge clk);
    end
    check(name, {31'd0, (i < max)}, 1);
  endtask

  task automatic wait_level_below(input int lvl, input int max, input string name);
    int i;
    for (i = 0; i < max; i++) begin
      if (int'(fifo_level) < lvl) break;
      @(negedge clk);
    end
    check(name, {31'd0, (i < max)}, 1);
  endtask

  task automatic wait_sclk_rises(input int n, input int max, input string name);
    int i;
    int seen;
    logic pc;
    seen = 0;
    pc   = spi_clk;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (spi_clk && !pc) seen++;
      pc = spi_clk;
      if (seen == n) break;
    end
    check(name, {31'd0, (i < max)}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic        any_drop;

    // Reset state while rstn is held low
    repeat (3) @(negedge clk);
    check("rst_csn",   {31'd0, spi_csn},  1);
    check("rst_sclk",  {31'd0, spi_clk},  0);
    check("rst_mosi",  {31'd0, spi_mosi}, 0);
    check("rst_busy",  {31'd0, busy},     0);
    check("rst_level", {29'd0, fifo_level}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single sample
    exp_q.push_back(16'h00A5);
    send(8'hA5);
    wait_drain(300, "t1_drain");
    check("t1_level_zero", {29'd0, fifo_level}, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: two samples ten cycles apart, back-to-back frames
    do_reset();
    exp_q.push_back(16'h0001);
    send(8'h01);
    repeat (9) @(negedge clk);
    exp_q.push_back(16'h0102);
    send(8'h02);
    wait_drain(400, "t2_drain");
    check("t2_csn_high_between", last_high, CS_GAP + 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: burst of 8 into a depth-4 FIFO, then a drop-flagged sample
    do_reset();
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0111);
    exp_q.push_back(16'h0212);
    exp_q.push_back(16'h0313);
    exp_q.push_back(16'h0414);
    for (int i = 0; i < 8; i++) begin
      sample_in  = 8'(8'h10 + i);
      sample_rdy = 1'b1;
      @(negedge clk);
    end
    sample_rdy = 1'b0;
    check("t3_level_full", {29'd0, fifo_level}, 4);
    wait_level_below(4, 200, "t3_space");
    exp_q.push_back(16'h883C);
    send(8'h3C);
    wait_drain(800, "t3_drain");
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: write in the IDLE pop cycle while full
    do_reset();
    exp_q.push_back(16'h0040);
    send(8'h40);
    wait_busy(1'b1, 10, "t4_first_pop");
    exp_q.push_back(16'h0141);
    exp_q.push_back(16'h0242);
    exp_q.push_back(16'h0343);
    exp_q.push_back(16'h0444);
    for (int i = 0; i < 4; i++) begin
      sample_in  = 8'(8'h41 + i);
      sample_rdy = 1'b1;
      @(negedge clk);
    end
    sample_rdy = 1'b0;
    check("t4_level_full", {29'd0, fifo_level}, 4);
    wait_busy(1'b0, 200, "t4_idle_cycle");
    exp_q.push_back(16'h0545);
    send(8'h45);
    check("t4_level_after_pop_write", {29'd0, fifo_level}, 4);
    check("t4_busy_after_pop", {31'd0, busy}, 1);
    wait_drain(800, "t4_drain");
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: 130 well-spaced samples, sequence wraps at 128
    do_reset();
    rx_log.delete();
    for (int i = 0; i < 130; i++) begin
      w = {1'b0, 7'(i), 8'(i)};
      exp_q.push_back(w);
      send(8'(i));
      repeat (78) @(negedge clk);
    end
    wait_drain(300, "t5_drain");
    check("t5_frame_count", rx_log.size(), 130);
    if (rx_log.size() > 128) begin
      check("t5_frame128_seq", {25'd0, rx_log[128][14:8]}, 0);
      check("t5_frame128_word", {16'd0, rx_log[128]}, 32'h0080);
    end
    any_drop = 1'b0;
    foreach (rx_log[k]) any_drop |= rx_log[k][15];
    check("t5_no_drop_bits", {31'd0, any_drop}, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: reset during the 5th bit of a frame
    do_reset();
    send(8'h77);
    wait_sclk_rises(5, 200, "t6_fifth_bit");
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_csn_on_reset",  {31'd0, spi_csn}, 1);
    check("t6_sclk_on_reset", {31'd0, spi_clk}, 0);
    check("t6_busy_on_reset", {31'd0, busy},    0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_level_after_reset", {29'd0, fifo_level}, 0);
    exp_q.push_back(16'h0099);
    send(8'h99);
    wait_drain(300, "t6_drain");
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
